// File: rtl/noc_out_fifo.sv
// Output flit buffer for one router output port: DEPTH x 32 first-word-fall-through
// FIFO with write-side packet framing checks, complete-packet count and sticky errors.
module noc_out_fifo #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          FifoWr_i,
    input  logic [31:0]   FifoWrData_i,
    output logic          FifoFull_o,
    output logic          Valid_o,
    output logic [31:0]   Data_o,
    input  logic          Ready_i,
    output logic [CW-1:0] Count_o,
    output logic [CW-1:0] PktCnt_o,
    output logic          OvfErr_o,
    output logic          FrmErr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic {
        IDLE,
        INPKT
    } frm_state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] pkt_cnt;
    frm_state_t    frm_state;
    logic          ovf_err;
    logic          frm_err;

    logic          wr_en;
    logic          rd_en;
    logic          wr_tail;
    logic          rd_tail;
    logic [1:0]    wr_type;

    // Status decodes come only from registered state, so neither handshake input
    // has a combinational path to any output.
    assign FifoFull_o = (count == FULL_CNT);
    assign Valid_o    = (count != '0);
    assign Data_o     = Valid_o ? mem[rd_ptr] : 32'h0;
    assign Count_o    = count;
    assign PktCnt_o   = pkt_cnt;
    assign OvfErr_o   = ovf_err;
    assign FrmErr_o   = frm_err;

    assign wr_en   = FifoWr_i & ~FifoFull_o;
    assign rd_en   = Valid_o & Ready_i;
    assign wr_type = FifoWrData_i[31:30];
    assign wr_tail = (wr_type == TYPE_TAIL);
    assign rd_tail = (Data_o[31:30] == TYPE_TAIL);

    // Storage is deliberately left unreset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= FifoWrData_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Complete packets = tail flits currently held in the buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt <= '0;
        end else begin
            case ({wr_en & wr_tail, rd_en & rd_tail})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_err <= 1'b0;
        end else if (FifoWr_i && FifoFull_o) begin
            ovf_err <= 1'b1;
        end
    end

    // Framing tracker: errored flits are still stored, only the flag records them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frm_state <= IDLE;
            frm_err   <= 1'b0;
        end else if (wr_en) begin
            case (frm_state)
                IDLE: begin
                    if (wr_type == TYPE_HEAD) begin
                        frm_state <= INPKT;
                    end else begin
                        frm_err <= 1'b1;
                    end
                end
                INPKT: begin
                    if (wr_tail) begin
                        frm_state <= IDLE;
                    end else if (wr_type == TYPE_HEAD) begin
                        frm_err <= 1'b1;
                    end
                end
                default: frm_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_out_fifo.sv
// Self-checking bench for noc_out_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_noc_out_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic          FifoWr_i;
    logic [31:0]   FifoWrData_i;
    logic          FifoFull_o;
    logic          Valid_o;
    logic [31:0]   Data_o;
    logic          Ready_i;
    logic [CW-1:0] Count_o;
    logic [CW-1:0] PktCnt_o;
    logic          OvfErr_o;
    logic          FrmErr_o;

    int checks;
    int failures;

    noc_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .FifoWr_i     (FifoWr_i),
        .FifoWrData_i (FifoWrData_i),
        .FifoFull_o   (FifoFull_o),
        .Valid_o      (Valid_o),
        .Data_o       (Data_o),
        .Ready_i      (Ready_i),
        .Count_o      (Count_o),
        .PktCnt_o     (PktCnt_o),
        .OvfErr_o     (OvfErr_o),
        .FrmErr_o     (FrmErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] din;
        logic        rdy;
        logic        valid;
        logic [31:0] dout;
        int          cnt;
        int          pkt;
        logic        full;
        logic        ovf;
        logic        frm;
    } vec_t;

    vec_t tbl [15];

    // Reference model state
    logic [31:0] mq [$];
    logic        m_inpkt;
    logic        m_ovf;
    logic        m_frm;

    task automatic checkOutput(input string name, input logic valid, input logic [31:0] data,
                               input int cnt, input int pkt, input logic full,
                               input logic ovf, input logic frm);
        checks += 7;
        if (Valid_o !== valid) begin
            failures++;
            $display("[TB] FAIL %s.valid actual=%0b required=%0b", name, Valid_o, valid);
        end
        if (Data_o !== data) begin
            failures++;
            $display("[TB] FAIL %s.data actual=%h required=%h", name, Data_o, data);
        end
        if (int'(Count_o) != cnt || $isunknown(Count_o)) begin
            failures++;
            $display("[TB] FAIL %s.count actual=%0d required=%0d", name, Count_o, cnt);
        end
        if (int'(PktCnt_o) != pkt || $isunknown(PktCnt_o)) begin
            failures++;
            $display("[TB] FAIL %s.pktcnt actual=%0d required=%0d", name, PktCnt_o, pkt);
        end
        if (FifoFull_o !== full) begin
            failures++;
            $display("[TB] FAIL %s.full actual=%0b required=%0b", name, FifoFull_o, full);
        end
        if (OvfErr_o !== ovf) begin
            failures++;
            $display("[TB] FAIL %s.ovf actual=%0b required=%0b", name, OvfErr_o, ovf);
        end
        if (FrmErr_o !== frm) begin
            failures++;
            $display("[TB] FAIL %s.frm actual=%0b required=%0b", name, FrmErr_o, frm);
        end
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic applyStimulus(input logic wr, input logic [31:0] din, input logic rdy);
        FifoWr_i     = wr;
        FifoWrData_i = din;
        Ready_i      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        FifoWr_i     = 1'b0;
        FifoWrData_i = 32'h0;
        Ready_i      = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mq.delete();
        m_inpkt = 1'b0;
        m_ovf   = 1'b0;
        m_frm   = 1'b0;
    endtask

    // Model step: evaluate acceptance from pre-edge state, then update.
    task automatic modelStep(input logic wr, input logic [31:0] din, input logic rdy);
        logic wr_acc;
        logic rd_acc;
        logic [1:0] t;
        wr_acc = wr && (mq.size() < DEPTH);
        rd_acc = rdy && (mq.size() > 0);
        if (wr && mq.size() == DEPTH) m_ovf = 1'b1;
        if (rd_acc) void'(mq.pop_front());
        if (wr_acc) begin
            mq.push_back(din);
            t = din[31:30];
            if (!m_inpkt) begin
                if (t == 2'b00) m_inpkt = 1'b1;
                else m_frm = 1'b1;
            end else begin
                if (t == 2'b11) m_inpkt = 1'b0;
                else if (t == 2'b00) m_frm = 1'b1;
            end
        end
    endtask

    function automatic int modelPkts();
        int n;
        n = 0;
        foreach (mq[i]) if (mq[i][31:30] == 2'b11) n++;
        return n;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b1;
        FifoWr_i = 1'b0;
        FifoWrData_i = 32'h0;
        Ready_i  = 1'b0;

        // wr, din, rdy | valid, dout, cnt, pkt, full, ovf, frm
        tbl[0]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h4000_0002, 1'b0, 1'b1, 32'h0000_0001, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'hC000_0003, 1'b0, 1'b1, 32'h0000_0001, 3, 1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4000_0002, 2, 1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC000_0003, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0010, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 32'h4000_0011, 1'b0, 1'b1, 32'h0000_0010, 2, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'h8000_0012, 1'b0, 1'b1, 32'h0000_0010, 3, 0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'hC000_0013, 1'b0, 1'b1, 32'h0000_0010, 4, 1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'h0000_0099, 1'b0, 1'b1, 32'h0000_0010, 4, 1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_00AA, 1'b1, 1'b1, 32'h4000_0011, 3, 1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0012, 2, 1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC000_0013, 1, 1, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         0, 0, 1'b0, 1'b1, 1'b0};

        doReset();
        checkOutput("reset", 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].wr, tbl[i].din, tbl[i].rdy);
            checkOutput($sformatf("vec%0d", i), tbl[i].valid, tbl[i].dout, tbl[i].cnt,
                        tbl[i].pkt, tbl[i].full, tbl[i].ovf, tbl[i].frm);
        end

        // Body flit straight out of reset is a framing error but is still stored.
        doReset();
        applyStimulus(1'b1, 32'h4000_0000, 1'b0);
        checkOutput("frm_body", 1'b1, 32'h4000_0000, 1, 0, 1'b0, 1'b0, 1'b1);

        // Head followed by head.
        doReset();
        applyStimulus(1'b1, 32'h0000_0005, 1'b0);
        checkOutput("frm_h1", 1'b1, 32'h0000_0005, 1, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0006, 1'b0);
        checkOutput("frm_h2", 1'b1, 32'h0000_0005, 2, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset with an open packet buffered, then a clean new head.
        doReset();
        applyStimulus(1'b1, 32'h0000_0007, 1'b0);
        applyStimulus(1'b1, 32'h4000_0008, 1'b0);
        applyStimulus(1'b1, 32'h4000_0009, 1'b0);
        FifoWr_i = 1'b0;
        checkOutput("open3", 1'b1, 32'h0000_0007, 3, 0, 1'b0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_rst", 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b1, 32'h0000_000A, 1'b0);
        checkOutput("post_rst_head", 1'b1, 32'h0000_000A, 1, 0, 1'b0, 1'b0, 1'b0);

        // Streaming a 10-flit packet with the consumer always ready.
        doReset();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] f;
            f = (i == 0) ? 32'h0000_0100 : ((i == 9) ? 32'hC000_0109 : (32'h4000_0100 + i));
            applyStimulus(1'b1, f, 1'b1);
            checkOutput($sformatf("stream%0d", i), 1'b1, f, 1, (i == 9) ? 1 : 0,
                        1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("stream_end", 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            logic        wr;
            logic        rdy;
            logic [31:0] d;
            wr  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 4);
            d   = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                d[31:30] = m_inpkt ? (($urandom_range(0, 2) == 0) ? 2'b11 : 2'b01) : 2'b00;
            end
            modelStep(wr, d, rdy);
            applyStimulus(wr, d, rdy);
            checkOutput($sformatf("rnd%0d", n), mq.size() > 0,
                        (mq.size() > 0) ? mq[0] : 32'h0, mq.size(), modelPkts(),
                        mq.size() == DEPTH, m_ovf, m_frm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
